// File: rtl/fnd_digit_driver.sv
// rtl/fnd_digit_driver.sv - 6-digit FND output stage: dead-time blanking, double-buffered data, leading-zero suppression
module fnd_digit_driver #(
    parameter int BLANK_CYCLES = 4,
    parameter bit LZ_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  i_sel,
    input  logic [23:0] i_bcd,
    input  logic [5:0]  i_dp,
    input  logic        i_load,
    output logic [5:0]  o_an,
    output logic [7:0]  o_seg
);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_DRIVE,
        ST_OFF
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(BLANK_CYCLES - 1);

    logic [2:0]  r_sel_d;
    state_t      state;
    logic [7:0]  cnt;
    logic [23:0] pend_bcd;
    logic [5:0]  pend_dp;
    logic        pend_valid;
    logic [23:0] disp_bcd;
    logic [5:0]  disp_dp;

    logic        change;
    logic        sel_valid;
    logic        swap;
    logic [5:0]  lead_zero;
    logic        zero_run;
    logic [3:0]  sel_digit;
    logic        sel_dp;
    logic        sel_lz;
    logic [6:0]  seg7;
    logic [5:0]  drive_an;
    logic [7:0]  drive_seg;

    assign change    = (i_sel != r_sel_d);
    assign sel_valid = (i_sel <= 3'd5);
    assign swap      = change && (i_sel == 3'd0);

    // Leading-zero run is scanned from digit 5 down; digit 0 is never suppressed.
    always_comb begin
        lead_zero = '0;
        zero_run  = LZ_EN;
        for (int n = 5; n >= 1; n--) begin
            zero_run     = zero_run && (disp_bcd[4*n +: 4] == 4'h0);
            lead_zero[n] = zero_run;
        end
    end

    always_comb begin
        sel_digit = 4'h0;
        sel_dp    = 1'b0;
        sel_lz    = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (i_sel == 3'(n)) begin
                sel_digit = disp_bcd[4*n +: 4];
                sel_dp    = disp_dp[n];
                sel_lz    = lead_zero[n];
            end
        end
    end

    always_comb begin
        case (sel_digit)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
        if (sel_lz) begin
            seg7 = 7'h7F;
        end
        drive_seg = {~sel_dp, seg7};
        drive_an  = sel_valid ? ~(6'b000001 << i_sel) : 6'h3F;
    end

    // Outputs are registered from the next state, so the blank window starts on the change edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_d <= 3'd0;
            state   <= ST_BLANK;
            cnt     <= CNT_INIT;
            o_an    <= 6'h3F;
            o_seg   <= 8'hFF;
        end else begin
            r_sel_d <= i_sel;
            if (change) begin
                state <= sel_valid ? ST_BLANK : ST_OFF;
                cnt   <= CNT_INIT;
                o_an  <= 6'h3F;
                o_seg <= 8'hFF;
            end else begin
                case (state)
                    ST_BLANK: begin
                        if (cnt == 8'd0) begin
                            state <= ST_DRIVE;
                            o_an  <= drive_an;
                            o_seg <= drive_seg;
                        end else begin
                            cnt   <= cnt - 8'd1;
                            o_an  <= 6'h3F;
                            o_seg <= 8'hFF;
                        end
                    end
                    ST_DRIVE: begin
                        o_an  <= drive_an;
                        o_seg <= drive_seg;
                    end
                    default: begin
                        o_an  <= 6'h3F;
                        o_seg <= 8'hFF;
                    end
                endcase
            end
        end
    end

    // A load coinciding with the frame swap bypasses the pending buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_bcd   <= 24'h0;
            pend_dp    <= 6'h0;
            pend_valid <= 1'b0;
            disp_bcd   <= 24'h0;
            disp_dp    <= 6'h0;
        end else if (swap) begin
            pend_valid <= 1'b0;
            if (i_load) begin
                disp_bcd <= i_bcd;
                disp_dp  <= i_dp;
            end else if (pend_valid) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
            end
        end else if (i_load) begin
            pend_bcd   <= i_bcd;
            pend_dp    <= i_dp;
            pend_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fnd_digit_driver.sv
// tb/tb_fnd_digit_driver.sv - self-checking bench for fnd_digit_driver (LZ on and off instances)
module tb_fnd_digit_driver;

    localparam int BLANK = 4;

    logic        clk;
    logic        reset;
    logic [2:0]  i_sel;
    logic [23:0] i_bcd;
    logic [5:0]  i_dp;
    logic        i_load;
    logic [5:0]  an1, an0;
    logic [7:0]  seg1, seg0;

    int checks;
    int failures;

    fnd_digit_driver #(.BLANK_CYCLES(BLANK), .LZ_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .i_sel(i_sel), .i_bcd(i_bcd), .i_dp(i_dp),
        .i_load(i_load), .o_an(an1), .o_seg(seg1)
    );

    fnd_digit_driver #(.BLANK_CYCLES(BLANK), .LZ_EN(1'b0)) dut_nolz (
        .clk(clk), .reset(reset), .i_sel(i_sel), .i_bcd(i_bcd), .i_dp(i_dp),
        .i_load(i_load), .o_an(an0), .o_seg(seg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  pat [0:9];
    logic [23:0] m_disp, m_pend;
    logic [5:0]  m_ddp, m_pdp;
    logic        m_pv;
    logic [2:0]  m_prev;
    int          m_since;
    logic        m_valid;
    logic [5:0]  e_an;
    logic [7:0]  e_seg1, e_seg0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [23:0] v, input logic [5:0] dp,
                                             input int n, input bit lz);
        logic [23:0] upper;
        int          d;
        logic [6:0]  low;
        upper = v >> (4 * n);
        d     = int'(upper & 24'hF);
        if (lz && n >= 1 && upper == 24'h0) low = 7'h7F;
        else if (d < 10)                    low = pat[d][6:0];
        else                                low = 7'h3F;
        return {~dp[n], low};
    endfunction

    // Model: a digit is shown once its select has been stable for BLANK edges since the last change.
    initial begin
        m_valid = 1'b0;
        m_since = 0;
        m_prev  = 3'd0;
        m_pv    = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_since = 0;
                m_prev  = 3'd0;
                m_disp  = 24'h0;
                m_ddp   = 6'h0;
                m_pv    = 1'b0;
                m_valid = 1'b1;
            end else begin
                if (i_sel != m_prev && i_sel == 3'd0) begin
                    if (i_load) begin
                        m_disp = i_bcd;
                        m_ddp  = i_dp;
                    end else if (m_pv) begin
                        m_disp = m_pend;
                        m_ddp  = m_pdp;
                    end
                    m_pv = 1'b0;
                end else if (i_load) begin
                    m_pend = i_bcd;
                    m_pdp  = i_dp;
                    m_pv   = 1'b1;
                end
                if (i_sel != m_prev) m_since = 0;
                else if (m_since < 1000) m_since = m_since + 1;
                m_prev = i_sel;
            end
            if (!reset && i_sel <= 3'd5 && m_since >= BLANK) begin
                e_an   = ~(6'b000001 << i_sel);
                e_seg1 = model_seg(m_disp, m_ddp, int'(i_sel), 1'b1);
                e_seg0 = model_seg(m_disp, m_ddp, int'(i_sel), 1'b0);
            end else begin
                e_an   = 6'h3F;
                e_seg1 = 8'hFF;
                e_seg0 = 8'hFF;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("model_an_lz",    {2'b00, an1}, {2'b00, e_an});
                check("model_seg_lz",   seg1, e_seg1);
                check("model_an_nolz",  {2'b00, an0}, {2'b00, e_an});
                check("model_seg_nolz", seg0, e_seg0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pat[0] = 8'hC0; pat[1] = 8'hF9; pat[2] = 8'hA4; pat[3] = 8'hB0; pat[4] = 8'h99;
        pat[5] = 8'h92; pat[6] = 8'h82; pat[7] = 8'hF8; pat[8] = 8'h80; pat[9] = 8'h90;
        reset = 1'b1; i_sel = 3'd0; i_bcd = 24'h0; i_dp = 6'h0; i_load = 1'b0;
        tick(2);
        reset = 1'b0;

        // Reset, hold select 0.
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rst_blank_an", {2'b00, an1}, 8'h3F);
            check("rst_blank_seg", seg1, 8'hFF);
        end
        tick(1);
        check("rst_drive_an", {2'b00, an1}, 8'h3E);
        check("rst_drive_seg", seg1, 8'hC0);

        // Load while in frame; old data until the wrap to 0.
        i_bcd = 24'h012345; i_dp = 6'b000100; i_load = 1'b1;
        tick(1);
        i_load = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            i_sel = 3'(s);
            tick(20);
            check("old_an", {2'b00, an1}, {2'b00, ~(6'b000001 << s)});
            check("old_seg_lz", seg1, 8'hFF);
            check("old_seg_nolz", seg0, 8'hC0);
        end
        i_sel = 3'd0;
        tick(20);
        check("new_d0", seg1, 8'h92);
        for (int s = 1; s <= 5; s++) begin
            i_sel = 3'(s);
            tick(20);
            if (s == 2) begin
                check("new_d2_lz", seg1, 8'h30);
                check("new_d2_nolz", seg0, 8'h30);
            end
            if (s == 5) begin
                check("new_d5_lz", seg1, 8'hFF);
                check("new_d5_nolz", seg0, 8'hC0);
            end
        end

        // Select changes every 2 clocks never reach a driven digit.
        for (int k = 0; k < 12; k++) begin
            i_sel = 3'(k % 6);
            for (int t = 0; t < 2; t++) begin
                tick(1);
                check("fast_an", {2'b00, an1}, 8'h3F);
            end
        end

        // Invalid select, then move to 3.
        i_sel = 3'd6;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            check("off_an", {2'b00, an1}, 8'h3F);
        end
        i_sel = 3'd3;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            check("off_blank_an", {2'b00, an1}, 8'h3F);
        end
        tick(1);
        check("off_drive_an", {2'b00, an1}, 8'h37);
        check("off_drive_seg", seg1, 8'hA4);

        // Non-decimal digit shows a dash.
        i_sel = 3'd1;
        tick(6);
        i_bcd = 24'h00000B; i_dp = 6'h0; i_load = 1'b1;
        tick(1);
        i_load = 1'b0;
        i_sel = 3'd0;
        tick(5);
        check("dash_an", {2'b00, an1}, 8'h3E);
        check("dash_lz", seg1, 8'hBF);
        check("dash_nolz", seg0, 8'hBF);
        for (int s = 1; s <= 5; s++) begin
            i_sel = 3'(s);
            tick(5);
            check("dash_hi_nolz", seg0, 8'hC0);
            check("dash_hi_lz", seg1, 8'hFF);
        end

        // Load on the swap edge, then reset mid-drive with pending data.
        i_sel = 3'd0; i_bcd = 24'h000042; i_dp = 6'b000001; i_load = 1'b1;
        tick(1);
        i_load = 1'b0;
        tick(4);
        check("swapload_d0", seg1, 8'h24);
        i_sel = 3'd1;
        tick(5);
        check("swapload_d1", seg1, 8'h99);
        i_bcd = 24'h999999; i_dp = 6'h3F; i_load = 1'b1;
        tick(1);
        i_load = 1'b0;
        reset = 1'b1; i_sel = 3'd0;
        tick(1);
        check("midrst_an", {2'b00, an1}, 8'h3F);
        check("midrst_seg", seg1, 8'hFF);
        check("midrst_seg_nolz", seg0, 8'hFF);
        reset = 1'b0;
        tick(4);
        check("postrst_d0", seg1, 8'hC0);
        i_sel = 3'd1;
        tick(5);
        check("postrst_d1_nolz", seg0, 8'hC0);
        i_sel = 3'd0;
        tick(5);
        check("postrst_discard", seg1, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
